// File: rtl/fsm_mon_pkg.sv
// rtl/fsm_mon_pkg.sv - shared types, one-hot constants and step rule for the sequence monitor
package fsm_mon_pkg;

    // Control states of the monitor
    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_LOCKED   = 2'd1,
        ST_ERROR    = 2'd2
    } mon_state_t;

    // Error classes reported on err_code
    typedef enum logic [1:0] {
        ERR_NONE = 2'b00,
        ERR_ENC  = 2'b01,
        ERR_STEP = 2'b10,
        ERR_HOLD = 2'b11
    } err_code_t;

    // Sequencer words, one per index
    localparam logic [3:0] VEC_0 = 4'b0001;
    localparam logic [3:0] VEC_1 = 4'b0010;
    localparam logic [3:0] VEC_2 = 4'b0100;
    localparam logic [3:0] VEC_3 = 4'b1000;

    // True when moving between two different indices is an allowed step
    function automatic logic step_legal(input logic [1:0] from_idx, input logic [1:0] to_idx);
        case (from_idx)
            2'd0:    return (to_idx == 2'd1);
            2'd1:    return (to_idx == 2'd2) || (to_idx == 2'd3);
            2'd2:    return (to_idx == 2'd3);
            default: return (to_idx == 2'd0);
        endcase
    endfunction

endpackage

// File: rtl/onehot_dec.sv
// rtl/onehot_dec.sv - 4-bit one-hot word to 2-bit index with validity flag
module onehot_dec
    import fsm_mon_pkg::*;
(
    input  logic [3:0] i_vec,
    output logic [1:0] o_idx,
    output logic       o_valid
);

    // Decode exactly-one-hot words; anything else is flagged invalid
    always_comb begin
        o_idx   = 2'd0;
        o_valid = 1'b0;
        case (i_vec)
            VEC_0:   begin o_idx = 2'd0; o_valid = 1'b1; end
            VEC_1:   begin o_idx = 2'd1; o_valid = 1'b1; end
            VEC_2:   begin o_idx = 2'd2; o_valid = 1'b1; end
            VEC_3:   begin o_idx = 2'd3; o_valid = 1'b1; end
            default: begin o_idx = 2'd0; o_valid = 1'b0; end
        endcase
    end

endmodule

// File: rtl/fsm_monitor.sv
// rtl/fsm_monitor.sv - lock/track monitor for a one-hot sequencer word stream
module fsm_monitor
    import fsm_mon_pkg::*;
#(
    parameter int CNT_WIDTH = 8,
    parameter int HOLD_MAX  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [3:0]           vector,
    input  logic                 clr_err,
    output logic                 locked,
    output logic [1:0]           state_idx,
    output logic                 mode_det,
    output logic                 mode_valid,
    output logic [CNT_WIDTH-1:0] round_cnt,
    output logic                 err,
    output logic [1:0]           err_code
);

    localparam int HOLD_W = $clog2(HOLD_MAX + 1);

    mon_state_t           r_state,      w_state_nx;
    logic                 r_locked,     w_locked_nx;
    logic [1:0]           r_idx,        w_idx_nx;
    logic                 r_mode_det,   w_mode_det_nx;
    logic                 r_mode_valid, w_mode_valid_nx;
    logic [CNT_WIDTH-1:0] r_round,      w_round_nx;
    err_code_t            r_code,       w_code_nx;
    logic [HOLD_W-1:0]    r_hold,       w_hold_nx;

    logic [1:0]           w_dec_idx;
    logic                 w_dec_valid;
    logic [HOLD_W-1:0]    w_hold_inc;

    onehot_dec u_dec (
        .i_vec   (vector),
        .o_idx   (w_dec_idx),
        .o_valid (w_dec_valid)
    );

    assign w_hold_inc = r_hold + 1'b1;

    // State and output registers; reset dominates clear and enable
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_UNLOCKED;
            r_locked     <= 1'b0;
            r_idx        <= 2'd0;
            r_mode_det   <= 1'b0;
            r_mode_valid <= 1'b0;
            r_round      <= '0;
            r_code       <= ERR_NONE;
            r_hold       <= '0;
        end else begin
            r_state      <= w_state_nx;
            r_locked     <= w_locked_nx;
            r_idx        <= w_idx_nx;
            r_mode_det   <= w_mode_det_nx;
            r_mode_valid <= w_mode_valid_nx;
            r_round      <= w_round_nx;
            r_code       <= w_code_nx;
            r_hold       <= w_hold_nx;
        end
    end

    // Next-state: clear beats the sample; errors ranked encoding > step > hold
    always_comb begin
        w_state_nx      = r_state;
        w_locked_nx     = r_locked;
        w_idx_nx        = r_idx;
        w_mode_det_nx   = r_mode_det;
        w_mode_valid_nx = r_mode_valid;
        w_round_nx      = r_round;
        w_code_nx       = r_code;
        w_hold_nx       = r_hold;

        if (clr_err) begin
            w_state_nx      = ST_UNLOCKED;
            w_locked_nx     = 1'b0;
            w_code_nx       = ERR_NONE;
            w_mode_valid_nx = 1'b0;
            w_hold_nx       = '0;
        end else if (en) begin
            case (r_state)
                ST_UNLOCKED: begin
                    if (vector == VEC_0) begin
                        w_state_nx      = ST_LOCKED;
                        w_locked_nx     = 1'b1;
                        w_idx_nx        = 2'd0;
                        w_mode_valid_nx = 1'b0;
                        w_hold_nx       = '0;
                    end
                end
                ST_LOCKED: begin
                    if (!w_dec_valid) begin
                        w_state_nx = ST_ERROR;
                        w_code_nx  = ERR_ENC;
                    end else if (w_dec_idx == r_idx) begin
                        if (w_hold_inc == HOLD_W'(HOLD_MAX)) begin
                            w_state_nx = ST_ERROR;
                            w_code_nx  = ERR_HOLD;
                        end else begin
                            w_hold_nx = w_hold_inc;
                        end
                    end else if (!step_legal(r_idx, w_dec_idx)) begin
                        w_state_nx = ST_ERROR;
                        w_code_nx  = ERR_STEP;
                    end else begin
                        w_idx_nx  = w_dec_idx;
                        w_hold_nx = '0;
                        if (r_idx == 2'd1) begin
                            w_mode_valid_nx = 1'b1;
                            w_mode_det_nx   = (w_dec_idx == 2'd2);
                        end
                        if (r_idx == 2'd3) begin
                            w_round_nx = r_round + 1'b1;
                        end
                    end
                end
                ST_ERROR: begin
                    w_state_nx = ST_ERROR;
                end
                default: begin
                    w_state_nx = ST_UNLOCKED;
                end
            endcase
        end
    end

    assign locked     = r_locked;
    assign state_idx  = r_idx;
    assign mode_det   = r_mode_det;
    assign mode_valid = r_mode_valid;
    assign round_cnt  = r_round;
    assign err        = (r_state == ST_ERROR);
    assign err_code   = r_code;

endmodule

// File: tb/tb_fsm_monitor.sv
// tb/tb_fsm_monitor.sv - self-checking bench for fsm_monitor
module tb_fsm_monitor;

    localparam int HOLD_MAX = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       clr_err = 1'b0;
    logic [3:0] vector = 4'b0000;

    logic       locked, mode_det, mode_valid, err;
    logic [1:0] state_idx, err_code;
    logic [7:0] round_cnt;

    logic       w_locked, w_mode_det, w_mode_valid, w_err;
    logic [1:0] w_state_idx, w_err_code;
    logic [1:0] w_round_cnt;

    int checks = 0;
    int failures = 0;

    // Reference model state
    bit m_locked, m_err, m_md, m_mv;
    int m_idx, m_hold, m_round, m_code;
    bit [3:0] succ [4] = '{4'b0010, 4'b1100, 4'b1000, 4'b0001};

    fsm_monitor dut (
        .clk(clk), .rst(rst), .en(en), .vector(vector), .clr_err(clr_err),
        .locked(locked), .state_idx(state_idx), .mode_det(mode_det),
        .mode_valid(mode_valid), .round_cnt(round_cnt), .err(err), .err_code(err_code)
    );

    fsm_monitor #(.CNT_WIDTH(2)) dut_w (
        .clk(clk), .rst(rst), .en(en), .vector(vector), .clr_err(clr_err),
        .locked(w_locked), .state_idx(w_state_idx), .mode_det(w_mode_det),
        .mode_valid(w_mode_valid), .round_cnt(w_round_cnt), .err(w_err), .err_code(w_err_code)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] exp_bus();
        return {m_locked, 2'(m_idx), m_md, m_mv, 8'(m_round), m_err, 2'(m_code)};
    endfunction

    task automatic model_reset();
        m_locked = 0; m_err = 0; m_md = 0; m_mv = 0;
        m_idx = 0; m_hold = 0; m_round = 0; m_code = 0;
    endtask

    task automatic model_step(input logic e, input logic c, input logic [3:0] v);
        int n;
        if (c) begin
            m_err = 0; m_code = 0; m_mv = 0; m_hold = 0; m_locked = 0;
        end else if (e && !m_err) begin
            if (!m_locked) begin
                if (v == 4'b0001) begin m_locked = 1; m_idx = 0; m_hold = 0; end
            end else if ($countones(v) != 1) begin
                m_err = 1; m_code = 1;
            end else begin
                n = 0;
                for (int b = 0; b < 4; b++) if (v[b]) n = b;
                if (n == m_idx) begin
                    m_hold++;
                    if (m_hold >= HOLD_MAX) begin m_err = 1; m_code = 3; end
                end else if (!succ[m_idx][n]) begin
                    m_err = 1; m_code = 2;
                end else begin
                    if (m_idx == 1) begin m_mv = 1; m_md = (n == 2); end
                    if (m_idx == 3) m_round++;
                    m_idx = n; m_hold = 0;
                end
            end
        end
    endtask

    task automatic drive(input logic e, input logic c, input logic [3:0] v);
        en = e; clr_err = c; vector = v;
        @(posedge clk); #1;
        model_step(e, c, v);
    endtask

    task automatic do_reset();
        rst = 1; en = 1; clr_err = 1; vector = 4'b0001;
        @(posedge clk); #1;
        rst = 0; en = 0; clr_err = 0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if ({locked, state_idx, mode_det, mode_valid, round_cnt, err, err_code} !== 16'h0) begin
            failures++; $display("FAIL reset_outputs got=%h exp=0000", {locked, state_idx, mode_det, mode_valid, round_cnt, err, err_code}); end
        checks++; if (w_round_cnt !== 2'd0 || w_locked !== 1'b0) begin
            failures++; $display("FAIL reset_wide got=%0d/%0b exp=0/0", w_round_cnt, w_locked); end
        drive(1, 0, 4'b0001); drive(1, 0, 4'b0010); drive(1, 0, 4'b0100);
        do_reset();
        checks++; if ({locked, state_idx, mode_det, mode_valid, round_cnt, err, err_code} !== 16'h0) begin
            failures++; $display("FAIL reset_midround got=%h exp=0000", {locked, state_idx, mode_det, mode_valid, round_cnt, err, err_code}); end
    endtask

    task automatic test_mode1();
        do_reset();
        drive(1, 0, 4'b0001); drive(1, 0, 4'b0010);
        checks++; if (mode_valid !== 1'b0 || locked !== 1'b1 || state_idx !== 2'd1) begin
            failures++; $display("FAIL mode1_prebranch got mv=%0b lk=%0b idx=%0d exp mv=0 lk=1 idx=1", mode_valid, locked, state_idx); end
        drive(1, 0, 4'b0100); drive(1, 0, 4'b1000); drive(1, 0, 4'b0001);
        checks++; if ({locked, mode_det, mode_valid, err} !== 4'b1110) begin
            failures++; $display("FAIL mode1_flags got=%b exp=1110", {locked, mode_det, mode_valid, err}); end
        checks++; if (round_cnt !== 8'd1) begin
            failures++; $display("FAIL mode1_round got=%0d exp=1", round_cnt); end
    endtask

    task automatic test_mode0();
        do_reset();
        drive(1, 0, 4'b0001); drive(1, 0, 4'b0010); drive(1, 0, 4'b1000); drive(1, 0, 4'b0001);
        checks++; if ({mode_det, mode_valid} !== 2'b01) begin
            failures++; $display("FAIL mode0_flags got=%b exp=01", {mode_det, mode_valid}); end
        checks++; if (round_cnt !== 8'd1 || state_idx !== 2'd0) begin
            failures++; $display("FAIL mode0_round got=%0d idx=%0d exp=1 idx=0", round_cnt, state_idx); end
    endtask

    task automatic test_illegal_clear();
        do_reset();
        drive(1, 0, 4'b0001); drive(1, 0, 4'b0010); drive(1, 0, 4'b1000); drive(1, 0, 4'b0001);
        drive(1, 0, 4'b0100);
        checks++; if ({err, err_code} !== 3'b110) begin
            failures++; $display("FAIL illegal_err got=%b exp=110", {err, err_code}); end
        checks++; if (locked !== 1'b1 || state_idx !== 2'd0) begin
            failures++; $display("FAIL illegal_freeze got lk=%0b idx=%0d exp lk=1 idx=0", locked, state_idx); end
        drive(1, 0, 4'b0011); drive(1, 0, 4'b0001);
        checks++; if ({err, err_code, state_idx} !== 5'b11000) begin
            failures++; $display("FAIL error_sticky got=%b exp=11000", {err, err_code, state_idx}); end
        drive(0, 1, 4'b0000);
        checks++; if ({err, err_code, locked, mode_valid} !== 5'b00000) begin
            failures++; $display("FAIL clear_flags got=%b exp=00000", {err, err_code, locked, mode_valid}); end
        checks++; if (round_cnt !== 8'd1) begin
            failures++; $display("FAIL clear_round got=%0d exp=1", round_cnt); end
    endtask

    task automatic test_encoding();
        do_reset();
        drive(1, 0, 4'b0001); drive(1, 0, 4'b0011);
        checks++; if ({err, err_code} !== 3'b101) begin
            failures++; $display("FAIL enc_locked got=%b exp=101", {err, err_code}); end
        drive(0, 1, 4'b0000); drive(1, 0, 4'b0011); drive(1, 0, 4'b0000);
        checks++; if ({err, err_code, locked} !== 4'b0000) begin
            failures++; $display("FAIL enc_unlocked got=%b exp=0000", {err, err_code, locked}); end
    endtask

    task automatic test_hold();
        do_reset();
        drive(1, 0, 4'b0001); drive(1, 0, 4'b0010);
        for (int i = 0; i < 5; i++) drive(1, 0, 4'b0010);
        for (int i = 0; i < 30; i++) drive(0, 0, 4'b0010);
        checks++; if (err !== 1'b0) begin
            failures++; $display("FAIL hold_en_low got=%0b exp=0", err); end
        for (int i = 0; i < HOLD_MAX - 6; i++) drive(1, 0, 4'b0010);
        checks++; if (err !== 1'b0 || locked !== 1'b1) begin
            failures++; $display("FAIL hold_before_limit got err=%0b lk=%0b exp err=0 lk=1", err, locked); end
        drive(1, 0, 4'b0010);
        checks++; if ({err, err_code} !== 3'b111) begin
            failures++; $display("FAIL hold_timeout got=%b exp=111", {err, err_code}); end
    endtask

    task automatic test_clr_priority();
        do_reset();
        drive(1, 0, 4'b0001); drive(1, 1, 4'b0010);
        checks++; if ({locked, state_idx, err} !== 4'b0000) begin
            failures++; $display("FAIL clr_priority got=%b exp=0000", {locked, state_idx, err}); end
        drive(1, 0, 4'b0010);
        checks++; if (locked !== 1'b0) begin
            failures++; $display("FAIL unlocked_ignore got=%0b exp=0", locked); end
        drive(1, 0, 4'b0001); drive(0, 1, 4'b0000);
        checks++; if (locked !== 1'b0) begin
            failures++; $display("FAIL clr_en_low got=%0b exp=0", locked); end
    endtask

    task automatic test_wrap();
        do_reset();
        drive(1, 0, 4'b0001);
        for (int r = 1; r <= 4; r++) begin
            drive(1, 0, 4'b0010); drive(1, 0, 4'b1000); drive(1, 0, 4'b0001);
            checks++; if (w_round_cnt !== 2'(r % 4) || round_cnt !== 8'(r)) begin
                failures++; $display("FAIL wrap_round%0d got=%0d/%0d exp=%0d/%0d", r, w_round_cnt, round_cnt, r % 4, r); end
        end
    endtask

    task automatic test_random();
        logic [3:0] v;
        int n, sel;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(199) == 0) begin
                do_reset();
            end else begin
                sel = $urandom_range(99);
                if (sel < 55) begin
                    if (!m_locked || m_err) n = 0;
                    else if ($urandom_range(2) == 0) n = m_idx;
                    else n = (m_idx == 1) ? 2 + $urandom_range(1) : (m_idx == 2 ? 3 : (m_idx + 1) % 4);
                    v = 4'b0001 << n;
                end else if (sel < 85) begin
                    v = 4'b0001 << $urandom_range(3);
                end else begin
                    v = 4'($urandom_range(15));
                end
                drive($urandom_range(99) < 85, $urandom_range(99) < 3, v);
            end
            checks++; if ({locked, state_idx, mode_det, mode_valid, round_cnt, err, err_code} !== exp_bus()) begin
                failures++; $display("FAIL rand_cycle%0d got=%h exp=%h", i, {locked, state_idx, mode_det, mode_valid, round_cnt, err, err_code}, exp_bus()); end
            checks++; if (w_round_cnt !== 2'(m_round)) begin
                failures++; $display("FAIL rand_wide%0d got=%0d exp=%0d", i, w_round_cnt, m_round % 4); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_mode1();
        test_mode0();
        test_illegal_clear();
        test_encoding();
        test_hold();
        test_clr_priority();
        test_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fsm_monitor.md
FSM_MONITOR -- requirements
Module: fsm_monitor

Interface
REQ-001 The parameter CNT_WIDTH SHALL default to 8 and set the width of the round counter.
REQ-002 The parameter HOLD_MAX SHALL default to 16 and set the maximum number of consecutive identical samples tolerated while locked.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk  in  1  clock; all state changes on its rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 en  in  1  sample enable; when 1, vector is sampled on the clock edge.
REQ-007 vector  in  4  one-hot sequence word from the sequencer (0001, 0010, 0100, 1000).
REQ-008 clr_err  in  1  clears the sticky error and returns the block to UNLOCKED.
REQ-009 locked  out  1  1 while in state LOCKED.
REQ-010 state_idx  out  2  decoded index of the last legal sample (0001->0, 0010->1, 0100->2, 1000->3).
REQ-011 mode_det  out  1  mode inferred from the last branch taken after index 1.
REQ-012 mode_valid  out  1  1 once at least one branch has been observed since lock.
REQ-013 round_cnt  out  CNT_WIDTH  completed rounds (1000->0001), wrapping.
REQ-014 err  out  1  sticky error flag.
REQ-015 err_code  out  2  error type: 00 none, 01 encoding, 10 illegal transition, 11 hold timeout.

Function
REQ-016 All outputs SHALL be registered; each output SHALL reflect the sample taken at the same clock edge, so it is visible one cycle after the input.
REQ-017 When en=0, all state, counters and outputs SHALL hold.
REQ-018 Control states SHALL be UNLOCKED, LOCKED and ERROR.
REQ-019 In UNLOCKED, a sample of 0001 SHALL move the block to LOCKED with state_idx=0; every other sample, including non-one-hot values, SHALL be ignored.
REQ-020 In LOCKED, a non-one-hot sample SHALL move the block to ERROR with err_code=01.
REQ-021 In LOCKED, the legal steps SHALL be: a repeat of the same value; 0->1; 1->2; 1->3; 2->3; 3->0.
REQ-022 In LOCKED, any other step SHALL move the block to ERROR with err_code=10.
REQ-023 The step 1->2 SHALL set mode_det=1 and the step 1->3 SHALL set mode_det=0; either step SHALL set mode_valid=1.
REQ-024 The step 3->0 SHALL increment round_cnt, wrapping from 2^CNT_WIDTH-1 to 0.
REQ-025 A hold counter SHALL count consecutive identical samples while LOCKED and SHALL reset to 0 on any change of value.
REQ-026 When the hold counter reaches HOLD_MAX, the block SHALL move to ERROR with err_code=11.
REQ-027 If several errors apply to one sample, priority SHALL be 01 > 10 > 11.
REQ-028 On entry to ERROR, err SHALL be set to 1; locked, state_idx, mode_det, round_cnt and err_code SHALL freeze.
REQ-029 clr_err=1 SHALL move the block to UNLOCKED and set err=0, err_code=00, mode_valid=0 and the hold counter to 0; round_cnt SHALL be retained.
REQ-030 clr_err SHALL take priority over the sample in the same cycle, and that sample SHALL be discarded.
REQ-031 clr_err SHALL act regardless of en.

Reset
REQ-032 On rst=1, state SHALL be UNLOCKED and locked, state_idx, mode_det, mode_valid, round_cnt, err, err_code and the hold counter SHALL all be 0.
REQ-033 rst SHALL take priority over clr_err and en, including when asserted in the middle of a round.

Structure
REQ-034 Package fsm_mon_pkg SHALL hold the monitor state enum, the err_code enum and the four one-hot vector constants.
REQ-035 Sub-module onehot_dec SHALL convert the 4-bit vector to a 2-bit index plus a valid flag; the flag SHALL be 0 when the input is not exactly one-hot.

Verification
REQ-036 Mode-1 sequence: after rst, en=1 with vector 0001,0010,0100,1000,0001 -> locked=1, mode_det=1, mode_valid=1, round_cnt=1, err=0.
REQ-037 Mode-0 sequence: en=1 with vector 0001,0010,1000,0001 -> mode_det=0, mode_valid=1, round_cnt=1.
REQ-038 Illegal step and clear: in LOCKED with state_idx=0, drive 0100 -> err=1, err_code=10; then pulse clr_err -> err=0, locked=0; round_cnt is retained.
REQ-039 Encoding error: in LOCKED, drive 0011 -> err_code=01; in UNLOCKED, drive 0011 -> no error.
REQ-040 Hold timeout: in LOCKED, hold 0010 for 16 cycles -> err_code=11; with en=0 during the hold, no timeout occurs.
REQ-041 Counter wrap: with CNT_WIDTH=2, run 4 complete rounds -> round_cnt goes 1,2,3,0.
